credit_out_port: RTL and testbench

Reader/drain side of a router input buffer. The block pops flits from a local FIFO (using its peek/pop interface) and drives them onto a router output link. It requests the switch allocator once per packet and holds the grant for the whole packet (wormhole). Downstream buffer space is tracked with credits, so no flit is ever sent into a full downstream FIFO.

---
 rtl/noc_pkg.sv | 28 ++
 rtl/credit_counter.sv | 37 +++
 rtl/credit_out_port.sv | 127 ++++++++++++
 tb/tb_credit_out_port.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions for the router buffer drain logic.
// Contents:
//   CREDITS_DEFAULT - default downstream buffer depth and reset credit count
//   FIFO_DEPTH      - local FIFO depth, kept equal to the downstream depth
//   state_t         - drain FSM states
//   head_bit/tail_bit - flag bit positions within a flit of a given width
package noc_pkg;

  localparam int CREDITS_DEFAULT = 5;
  localparam int FIFO_DEPTH      = CREDITS_DEFAULT;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SEND
  } state_t;

  // The top bit of a flit marks the head.
  function automatic int head_bit(input int width);
    return width - 1;
  endfunction

  // The bit just below the head flag marks the tail.
  function automatic int tail_bit(input int width);
    return width - 2;
  endfunction

endpackage

// File: rtl/credit_counter.sv
// Downstream credit tracker for one output link.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   inc       - downstream freed a slot (credit returned)
//   dec       - a flit was sent downstream (credit consumed)
//   count     - credits currently available, resets to CREDITS
//   overflow  - single-cycle pulse when a credit returns while already full
module credit_counter #(
  parameter int CREDITS = 5,
  parameter int CNT_W   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(CREDITS);

  // A returned credit with nothing to absorb it while full means the
  // downstream side lost track of its own occupancy.
  assign overflow = inc && !dec && (count == MAX_CNT);

  // Saturating up/down counter. Simultaneous inc and dec cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= MAX_CNT;
    end else if (inc && !dec) begin
      if (count != MAX_CNT) count <= count + CNT_W'(1);
    end else if (dec && !inc) begin
      if (count != '0) count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/credit_out_port.sv
// Drain side of a router input buffer.
// Pops flits from the local FIFO, requests the switch allocator once per
// packet, holds the grant until the tail flit leaves (wormhole), and only
// sends while downstream credits are available.
// Ports:
//   clk, rst    - clock, asynchronous active-high reset
//   fifo_empty  - local FIFO empty
//   fifo_peek   - head-of-FIFO flit
//   fifo_pop    - combinational pop strobe to the local FIFO
//   credit_in   - one-cycle pulse, downstream freed one slot
//   alloc_req   - registered switch allocation request
//   alloc_gnt   - allocator grant, sampled while alloc_req is high
//   flit_out    - registered outgoing flit
//   flit_valid  - flit_out is valid this cycle
//   credit_cnt  - current credit count
//   err         - sticky protocol error flag
module credit_out_port
  import noc_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int CREDITS = CREDITS_DEFAULT,
  parameter int CNT_W   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_peek,
  output logic             fifo_pop,
  input  logic             credit_in,
  output logic             alloc_req,
  input  logic             alloc_gnt,
  output logic [WIDTH-1:0] flit_out,
  output logic             flit_valid,
  output logic [CNT_W-1:0] credit_cnt,
  output logic             err
);

  localparam int HEAD = head_bit(WIDTH);
  localparam int TAIL = tail_bit(WIDTH);

  state_t state;
  logic   first_flit;
  logic   peek_head;
  logic   peek_tail;
  logic   send_pop;
  logic   drop_pop;
  logic   credit_ovf;

  assign peek_head = fifo_peek[HEAD];
  assign peek_tail = fifo_peek[TAIL];

  // Sending uses the registered credit count, so a credit returned while at
  // zero only unblocks the link one cycle later.
  assign send_pop = (state == SEND) && !fifo_empty && (credit_cnt != '0);

  // A stray non-head flit at the FIFO head while idle is thrown away; it
  // never goes downstream and therefore does not consume a credit.
  assign drop_pop = (state == IDLE) && !fifo_empty && !peek_head;

  assign fifo_pop = send_pop || drop_pop;

  credit_counter #(
    .CREDITS (CREDITS),
    .CNT_W   (CNT_W)
  ) u_credit (
    .clk      (clk),
    .rst      (rst),
    .inc      (credit_in),
    .dec      (send_pop),
    .count    (credit_cnt),
    .overflow (credit_ovf)
  );

  // Drain FSM with registered request, flit and error outputs.
  // first_flit distinguishes the packet's own head from a stray head flit
  // that shows up in the middle of a packet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      alloc_req  <= 1'b0;
      flit_out   <= '0;
      flit_valid <= 1'b0;
      first_flit <= 1'b0;
      err        <= 1'b0;
    end else begin
      flit_valid <= 1'b0;
      if (credit_ovf) err <= 1'b1;

      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            if (peek_head) begin
              state     <= REQ;
              alloc_req <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end
        end

        REQ: begin
          if (alloc_gnt) begin
            state      <= SEND;
            alloc_req  <= 1'b0;
            first_flit <= 1'b1;
          end
        end

        SEND: begin
          if (send_pop) begin
            flit_out   <= fifo_peek;
            flit_valid <= 1'b1;
            first_flit <= 1'b0;
            if (peek_head && !first_flit) err <= 1'b1;
            if (peek_tail) state <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          alloc_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_credit_out_port.sv
// Scoreboard bench for credit_out_port.
// A queue models the local FIFO; flits expected downstream are pushed to a
// scoreboard queue when written into the FIFO and popped on flit_valid.
module tb_credit_out_port;

  logic        clk = 1'b0;
  logic        rst;
  logic        fifo_empty;
  logic [15:0] fifo_peek;
  logic        fifo_pop;
  logic        credit_in;
  logic        alloc_req;
  logic        alloc_gnt;
  logic [15:0] flit_out;
  logic        flit_valid;
  logic [2:0]  credit_cnt;
  logic        err;

  logic [15:0] fifo_q[$];
  logic [15:0] exp_q[$];
  logic [15:0] dropped;
  int          checks   = 0;
  int          failures = 0;
  int          sent     = 0;
  logic        last_pop;
  logic        any_req;

  credit_out_port #(
    .WIDTH   (16),
    .CREDITS (5),
    .CNT_W   (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_peek  (fifo_peek),
    .fifo_pop   (fifo_pop),
    .credit_in  (credit_in),
    .alloc_req  (alloc_req),
    .alloc_gnt  (alloc_gnt),
    .flit_out   (flit_out),
    .flit_valid (flit_valid),
    .credit_cnt (credit_cnt),
    .err        (err)
  );

  // Rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // Present the FIFO model's head to the DUT.
  task automatic syncFifo();
    fifo_empty = (fifo_q.size() == 0);
    fifo_peek  = fifo_empty ? 16'h0000 : fifo_q[0];
  endtask

  task automatic pushFlit(input logic [15:0] f, input bit expect_out);
    fifo_q.push_back(f);
    if (expect_out) exp_q.push_back(f);
    syncFifo();
  endtask

  // One clock: sample the pop strobe before the edge, then update the FIFO
  // model and score any outgoing flit just after the edge.
  task automatic applyStimulus();
    #2;
    last_pop = fifo_pop;
    @(posedge clk);
    #1;
    credit_in = 1'b0;
    if (last_pop === 1'b1 && fifo_q.size() > 0) dropped = fifo_q.pop_front();
    syncFifo();
    if (flit_valid === 1'b1) begin
      sent++;
      if (exp_q.size() == 0) checkOutput("unexpected_flit", {31'd0, flit_valid}, 32'd0);
      else checkOutput("flit", {16'd0, flit_out}, {16'd0, exp_q.pop_front()});
    end
  endtask

  task automatic waitReq();
    for (int i = 0; i < 20; i++) begin
      if (alloc_req === 1'b1) break;
      applyStimulus();
    end
    checkOutput("alloc_req_wait", {31'd0, alloc_req}, 32'd1);
  endtask

  task automatic grant();
    alloc_gnt = 1'b1;
    applyStimulus();
    alloc_gnt = 1'b0;
    checkOutput("alloc_req_drop", {31'd0, alloc_req}, 32'd0);
  endtask

  initial begin
    rst       = 1'b0;
    credit_in = 1'b0;
    alloc_gnt = 1'b0;
    syncFifo();

    // 1: asynchronous reset before any clock edge
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_credit", {29'd0, credit_cnt}, 32'd5);
    checkOutput("rst_req", {31'd0, alloc_req}, 32'd0);
    checkOutput("rst_valid", {31'd0, flit_valid}, 32'd0);
    checkOutput("rst_err", {31'd0, err}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;

    // 2: single head+tail flit
    sent = 0;
    pushFlit(16'hC00A, 1'b1);
    waitReq();
    grant();
    applyStimulus();
    checkOutput("t2_pop", {31'd0, last_pop}, 32'd1);
    checkOutput("t2_valid", {31'd0, flit_valid}, 32'd1);
    checkOutput("t2_credit", {29'd0, credit_cnt}, 32'd4);
    applyStimulus();
    checkOutput("t2_valid_drop", {31'd0, flit_valid}, 32'd0);
    checkOutput("t2_sent", sent, 32'd1);

    // 3: 7-flit packet limited by 5 credits
    credit_in = 1'b1;
    applyStimulus();
    checkOutput("t3_refill", {29'd0, credit_cnt}, 32'd5);
    sent = 0;
    pushFlit(16'h8001, 1'b1);
    for (int i = 2; i <= 6; i++) pushFlit(16'(i), 1'b1);
    pushFlit(16'h4007, 1'b1);
    waitReq();
    grant();
    repeat (8) applyStimulus();
    checkOutput("t3_sent5", sent, 32'd5);
    checkOutput("t3_credit0", {29'd0, credit_cnt}, 32'd0);
    #2;
    checkOutput("t3_pop_stall", {31'd0, fifo_pop}, 32'd0);
    credit_in = 1'b1;
    applyStimulus();
    applyStimulus();
    credit_in = 1'b1;
    applyStimulus();
    applyStimulus();
    applyStimulus();
    checkOutput("t3_sent7", sent, 32'd7);
    checkOutput("t3_credit_end", {29'd0, credit_cnt}, 32'd0);
    checkOutput("t3_scoreboard", exp_q.size(), 32'd0);
    checkOutput("t3_req_idle", {31'd0, alloc_req}, 32'd0);

    // 4: pop and credit return in the same cycle
    repeat (3) begin
      credit_in = 1'b1;
      applyStimulus();
    end
    checkOutput("t4_credit3", {29'd0, credit_cnt}, 32'd3);
    pushFlit(16'h8011, 1'b1);
    pushFlit(16'h4012, 1'b1);
    waitReq();
    grant();
    credit_in = 1'b1;
    applyStimulus();
    checkOutput("t4_pop", {31'd0, last_pop}, 32'd1);
    checkOutput("t4_credit_hold", {29'd0, credit_cnt}, 32'd3);
    checkOutput("t4_valid", {31'd0, flit_valid}, 32'd1);
    applyStimulus();
    applyStimulus();
    checkOutput("t4_credit2", {29'd0, credit_cnt}, 32'd2);
    checkOutput("t4_scoreboard", exp_q.size(), 32'd0);

    // 5: stray body flit while idle is dropped
    checkOutput("t5_err_before", {31'd0, err}, 32'd0);
    sent = 0;
    pushFlit(16'h0123, 1'b0);
    applyStimulus();
    checkOutput("t5_pop", {31'd0, last_pop}, 32'd1);
    checkOutput("t5_err", {31'd0, err}, 32'd1);
    any_req = alloc_req;
    repeat (4) begin
      applyStimulus();
      if (alloc_req === 1'b1) any_req = 1'b1;
    end
    checkOutput("t5_no_req", {31'd0, any_req}, 32'd0);
    checkOutput("t5_no_valid", sent, 32'd0);
    checkOutput("t5_fifo_drained", fifo_q.size(), 32'd0);

    // 6: credit overflow, then reset in the middle of a packet
    #2 rst = 1'b1;
    #1;
    checkOutput("t6_rst_err", {31'd0, err}, 32'd0);
    @(posedge clk);
    #3 rst = 1'b0;
    credit_in = 1'b1;
    applyStimulus();
    checkOutput("t6_sat", {29'd0, credit_cnt}, 32'd5);
    checkOutput("t6_ovf_err", {31'd0, err}, 32'd1);
    sent = 0;
    pushFlit(16'h8021, 1'b1);
    pushFlit(16'h0022, 1'b1);
    pushFlit(16'h4023, 1'b1);
    waitReq();
    grant();
    applyStimulus();
    checkOutput("t6_head_sent", sent, 32'd1);
    #2 rst = 1'b1;
    fifo_q.delete();
    exp_q.delete();
    syncFifo();
    #1;
    checkOutput("t6_mid_credit", {29'd0, credit_cnt}, 32'd5);
    checkOutput("t6_mid_err", {31'd0, err}, 32'd0);
    checkOutput("t6_mid_req", {31'd0, alloc_req}, 32'd0);
    checkOutput("t6_mid_valid", {31'd0, flit_valid}, 32'd0);
    @(posedge clk);
    #3 rst = 1'b0;
    sent = 0;
    pushFlit(16'hC055, 1'b1);
    waitReq();
    grant();
    applyStimulus();
    applyStimulus();
    checkOutput("t6_after_sent", sent, 32'd1);
    checkOutput("t6_after_credit", {29'd0, credit_cnt}, 32'd4);

    // 7: a second head inside a packet is forwarded and flagged
    checkOutput("t7_err_before", {31'd0, err}, 32'd0);
    sent = 0;
    pushFlit(16'h8031, 1'b1);
    pushFlit(16'h8032, 1'b1);
    pushFlit(16'h4033, 1'b1);
    waitReq();
    grant();
    repeat (5) applyStimulus();
    checkOutput("t7_sent", sent, 32'd3);
    checkOutput("t7_err", {31'd0, err}, 32'd1);
    checkOutput("t7_credit", {29'd0, credit_cnt}, 32'd1);
    checkOutput("t7_scoreboard", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
